// File: rtl/udp_csum_finalize_if.sv
// Header stream interface between udp_csum_finalize and the header inserter.
//   hdr_data   64  {src_port, dst_port, udp_len, checksum}
//   hdr_valid   1  hdr_data valid; held until accepted
//   hdr_ready   1  sink accepts hdr_data when hdr_valid=1
// Modports: master = header producer, slave = header consumer.
interface udp_csum_finalize_if;
  logic [63:0] hdr_data;
  logic        hdr_valid;
  logic        hdr_ready;

  modport master (output hdr_data, output hdr_valid, input hdr_ready);
  modport slave  (input hdr_data, input hdr_valid, output hdr_ready);
endinterface

// File: rtl/udp_csum_finalize.sv
// udp_csum_finalize
// Folds the IPv4 pseudo-header and UDP header words into a payload one's-complement
// sum, one word per cycle, and emits the final 64-bit UDP header
// {src_port, dst_port, udp_len, checksum} over a valid/ready stream.
// Optional feature macro: CSUM_BYPASS_EN (adds csum_bypass input; checksum forced to 0).
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   payload_sum        folded payload one's-complement sum
//   payload_sum_valid  1-cycle request strobe; header fields valid with it
//   src_ip, dst_ip     IPv4 addresses
//   src_port, dst_port UDP ports
//   udp_len            UDP length in bytes
//   csum_bypass        (CSUM_BYPASS_EN only) send checksum 16'h0000
//   hdr                header stream (master modport)
//   busy               1 whenever not IDLE
//   drop_cnt           saturating count of strobes discarded while busy
module udp_csum_finalize #(
  parameter logic [7:0] PROTO      = 8'h11,
  parameter int         DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           payload_sum,
  input  logic                  payload_sum_valid,
  input  logic [31:0]           src_ip,
  input  logic [31:0]           dst_ip,
  input  logic [15:0]           src_port,
  input  logic [15:0]           dst_port,
  input  logic [15:0]           udp_len,
`ifdef CSUM_BYPASS_EN
  input  logic                  csum_bypass,
`endif
  udp_csum_finalize_if.master   hdr,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t      state, state_next;
  logic [3:0]  idx;
  logic [15:0] acc;
  logic [31:0] src_ip_l, dst_ip_l;
  logic [15:0] src_port_l, dst_port_l, udp_len_l;
  logic        bypass_l;
  logic [63:0] hdr_data_r;
  logic        hdr_valid_r;
  logic [15:0] word;
  logic [15:0] acc_next;
  logic [15:0] csum;

  // 16-bit one's-complement add with end-around carry. Both operands are at most
  // 16'hFFFF, so the carry re-add cannot overflow again.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  // Transmitted checksum: complement of the total sum, with zero mapped to FFFF
  // because 0000 means "no checksum" in UDP over IPv4.
  function automatic logic [15:0] final_csum(input logic [15:0] sum, input logic byp);
    logic [15:0] c;
    c = ~sum;
    if (c == 16'h0000) c = 16'hFFFF;
    if (byp) c = 16'h0000;
    return c;
  endfunction

  assign busy          = (state != IDLE);
  assign hdr.hdr_data  = hdr_data_r;
  assign hdr.hdr_valid = hdr_valid_r;

  // Word sequence; the checksum field itself contributes 0 and is skipped.
  always_comb begin
    word = 16'h0000;
    case (idx)
      4'd0:    word = src_ip_l[31:16];
      4'd1:    word = src_ip_l[15:0];
      4'd2:    word = dst_ip_l[31:16];
      4'd3:    word = dst_ip_l[15:0];
      4'd4:    word = {8'h00, PROTO};
      4'd5:    word = udp_len_l;
      4'd6:    word = src_port_l;
      4'd7:    word = dst_port_l;
      4'd8:    word = udp_len_l;
      default: word = 16'h0000;
    endcase
  end

  assign acc_next = ones_add(acc, word);
  assign csum     = final_csum(acc_next, bypass_l);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (payload_sum_valid) state_next = ACC;
      ACC:     if (idx == 4'd8) state_next = OUT;
      OUT:     if (hdr_valid_r && hdr.hdr_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 16'h0000;
      idx         <= 4'd0;
      hdr_data_r  <= 64'h0;
      hdr_valid_r <= 1'b0;
      src_ip_l    <= 32'h0;
      dst_ip_l    <= 32'h0;
      src_port_l  <= 16'h0;
      dst_port_l  <= 16'h0;
      udp_len_l   <= 16'h0;
      bypass_l    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (payload_sum_valid) begin
            src_ip_l   <= src_ip;
            dst_ip_l   <= dst_ip;
            src_port_l <= src_port;
            dst_port_l <= dst_port;
            udp_len_l  <= udp_len;
`ifdef CSUM_BYPASS_EN
            bypass_l   <= csum_bypass;
`else
            bypass_l   <= 1'b0;
`endif
            acc        <= payload_sum;
            idx        <= 4'd0;
          end
        end
        ACC: begin
          acc <= acc_next;
          idx <= idx + 4'd1;
          // Last word: the header is built from the sum including this word.
          if (idx == 4'd8) begin
            hdr_data_r  <= {src_port_l, dst_port_l, udp_len_l, csum};
            hdr_valid_r <= 1'b1;
          end
        end
        OUT: begin
          if (hdr_valid_r && hdr.hdr_ready) hdr_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Requests arriving while busy are lost; count them, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (busy && payload_sum_valid && (drop_cnt != {DROP_CNT_W{1'b1}}))
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule
